// File: rtl/ibex_rf_wr_arbiter_if.sv
// Register-file write port sharing bundle: two valid/ready requesters
// (core, accelerator) plus the registered write port and forced-grant flag.
interface ibex_rf_wr_arbiter_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 core_valid_i;
  logic                 core_ready_o;
  logic [4:0]           core_waddr_i;
  logic [DataWidth-1:0] core_wdata_i;

  logic                 acc_valid_i;
  logic                 acc_ready_o;
  logic [4:0]           acc_waddr_i;
  logic [DataWidth-1:0] acc_wdata_i;

  logic                 rf_we_o;
  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 acc_forced_o;

  // Requester / register-file side.
  modport master (
    output core_valid_i, core_waddr_i, core_wdata_i,
    output acc_valid_i, acc_waddr_i, acc_wdata_i,
    input  core_ready_o, acc_ready_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o, acc_forced_o
  );

  // Arbiter side.
  modport slave (
    input  core_valid_i, core_waddr_i, core_wdata_i,
    input  acc_valid_i, acc_waddr_i, acc_wdata_i,
    output core_ready_o, acc_ready_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o, acc_forced_o
  );
endinterface

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: core has fixed priority, accelerator is force-granted after
// StarveLimit lost cycles. Optional perf counters via `define IBEX_RF_WR_ARB_PERF_EN.
module ibex_rf_wr_arbiter #(
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned StarveLimit = 4,
  parameter bit          RV32E       = 1'b0
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  ibex_rf_wr_arbiter_if.slave  bus
`ifdef IBEX_RF_WR_ARB_PERF_EN
  ,
  output logic [31:0]          perf_conflict_o,
  output logic [31:0]          perf_forced_o
`endif
);

  typedef enum logic [0:0] {
    CORE_PRIO = 1'b0,
    FORCE_ACC = 1'b1
  } state_e;

  localparam logic [3:0] StarveMax     = 4'd15;
  localparam logic [3:0] StarveTrigger = 4'(StarveLimit - 1);

  state_e               state_q, state_d;
  logic [3:0]           starve_cnt_q, starve_cnt_d;

  logic                 core_valid, acc_valid;
  logic                 core_gnt, acc_gnt;

  logic [4:0]           win_waddr;
  logic [DataWidth-1:0] win_wdata;
  logic                 win_is_x0;
  logic                 wr_en;

  logic                 rf_we_q;
  logic [4:0]           rf_waddr_q;
  logic [DataWidth-1:0] rf_wdata_q;

  assign core_valid = bus.core_valid_i;
  assign acc_valid  = bus.acc_valid_i;

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CORE_PRIO;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Grants are a pure function of the valids and the current state,
  // so neither ready can ever feed back into itself.
  always_comb begin
    state_d      = CORE_PRIO;
    starve_cnt_d = starve_cnt_q;
    core_gnt     = 1'b0;
    acc_gnt      = 1'b0;

    unique case (state_q)
      FORCE_ACC: begin
        // A withdrawn accelerator request ends the forced episode too.
        starve_cnt_d = '0;
        if (acc_valid) begin
          acc_gnt = 1'b1;
        end else begin
          core_gnt = core_valid;
        end
      end
      default: begin
        if (core_valid) begin
          core_gnt = 1'b1;
          if (acc_valid) begin
            if (starve_cnt_q != StarveMax) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
            if (starve_cnt_q == StarveTrigger) begin
              state_d = FORCE_ACC;
            end
          end
        end else if (acc_valid) begin
          acc_gnt      = 1'b1;
          starve_cnt_d = '0;
        end
      end
    endcase
  end

  assign bus.core_ready_o = core_gnt;
  assign bus.acc_ready_o  = acc_gnt;
  assign bus.acc_forced_o = (state_q == FORCE_ACC);

  assign win_waddr = acc_gnt ? bus.acc_waddr_i : bus.core_waddr_i;
  assign win_wdata = acc_gnt ? bus.acc_wdata_i : bus.core_wdata_i;

  // Under RV32E only the low four address bits select the register.
  assign win_is_x0 = RV32E ? (win_waddr[3:0] == 4'd0) : (win_waddr == 5'd0);
  assign wr_en     = (core_gnt | acc_gnt) & ~win_is_x0;

  // Address/data only move on a real write, so idle and x0 cycles hold them.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= wr_en;
      if (wr_en) begin
        rf_waddr_q <= win_waddr;
        rf_wdata_q <= win_wdata;
      end
    end
  end

  assign bus.rf_we_o    = rf_we_q;
  assign bus.rf_waddr_o = rf_waddr_q;
  assign bus.rf_wdata_o = rf_wdata_q;

`ifdef IBEX_RF_WR_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_forced_q;

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_conflict_q <= '0;
      perf_forced_q   <= '0;
    end else begin
      if (core_valid && acc_valid) begin
        perf_conflict_q <= perf_conflict_q + 32'd1;
      end
      if (acc_gnt && (state_q == FORCE_ACC)) begin
        perf_forced_q <= perf_forced_q + 32'd1;
      end
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_forced_o   = perf_forced_q;
`endif

  a_one_ready : assert property (@(posedge clk_int) disable iff (!rst_ni)
    !(core_gnt && acc_gnt));
  a_ready_needs_valid : assert property (@(posedge clk_int) disable iff (!rst_ni)
    (!core_gnt || core_valid) && (!acc_gnt || acc_valid));

endmodule
